// File: rtl/core8_cpu_oci_trace_collector.sv
// OCI data-trace capture FIFO (FWFT) with overflow counting and end-of-test drain tracking.
// Optional timestamp column in the word MSBs is enabled by defining CORE8_OCI_TRACE_TS_EN.
module core8_cpu_oci_trace_collector #(
    parameter int DCT_W = 30,
    parameter int CNT_W = 4,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16,
`ifdef CORE8_OCI_TRACE_TS_EN
    localparam int TSB   = TS_W,
`else
    localparam int TSB   = 0 * TS_W,
`endif
    localparam int W     = TSB + CNT_W + DCT_W,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DCT_W-1:0] dct_buffer,
    input  logic [CNT_W-1:0] dct_count,
    input  logic             dct_push,
    input  logic             test_ending,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [15:0]      overflow_cnt,
    output logic             test_has_ended
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [15:0]      ovf_q;
    logic             ended_q;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     word_in;

    logic full;
    logic push_req;
    logic push;
    logic pop;
    logic drop;

`ifdef CORE8_OCI_TRACE_TS_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign word_in = {ts_q, dct_count, dct_buffer};
`else
    assign word_in = {dct_count, dct_buffer};
`endif

    // Full/empty come from the occupancy count, so pointers may simply wrap.
    assign full      = (level_q == LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign pop       = out_valid & out_ready;
    assign push_req  = (state_q == RUN) & dct_push & (dct_count != '0);
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign level_d   = level_q + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
            ended_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
            unique case (state_q)
                RUN: begin
                    if (test_ending) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (level_d == '0) begin
                        state_q <= DONE;
                        ended_q <= 1'b1;
                    end
                end
                DONE: begin
                    ended_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    // Stale storage is masked so the empty head reads as zero after reset.
    assign out_data       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level     = level_q;
    assign overflow_cnt   = ovf_q;
    assign test_has_ended = ended_q;

endmodule

// File: doc/core8_cpu_oci_trace_collector.md
# core8_cpu_oci_trace_collector

Parametrised successor to the CPU OCI test-bench trace sink. Captures packed data-trace (DCT) words and their entry counts from the OCI into a first-word-fall-through FIFO, drains them over a valid/ready stream, counts dropped words, and reports end-of-test only once every captured word has been delivered. Sits between each core's OCI trace path and the simulation/debug trace consumer in the 8-core system.

## Interface
Parameters:
- DCT_W, 30, width of dct_buffer (packed trace slots)
- CNT_W, 4, width of dct_count
- DEPTH, 16, FIFO entries; power of two, 2..256
- TS_W, 16, timestamp width; used only with CORE8_OCI_TRACE_TS_EN

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- dct_buffer  in  DCT_W  packed trace payload
- dct_count  in  CNT_W  number of valid slots in dct_buffer; 0 = nothing to capture
- dct_push  in  1  capture strobe, one word per cycle
- test_ending  in  1  level; request to stop capture and drain
- out_data  out  W  head word {dct_count, dct_buffer}; W = CNT_W+DCT_W (+TS_W in MSBs with macro)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head word
- fifo_level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- overflow_cnt  out  16  dropped-push count, saturating
- test_has_ended  out  1  sticky; all captured words delivered after test_ending

## Operation
- States: RUN (reset), DRAIN, DONE.
- Push accepted iff state==RUN && dct_push && dct_count!=0 && (level<DEPTH || pop this cycle).
- Pop iff out_valid && out_ready. Simultaneous push+pop: level unchanged, both performed, including when full.
- Push with dct_count==0: ignored, not counted.
- Push in RUN when full with no pop: word dropped, overflow_cnt +1, saturates at 16'hFFFF.
- Pushes in DRAIN/DONE: ignored, not counted.
- RUN -> DRAIN on clock edge where test_ending==1 (a push in that same cycle is still accepted).
- DRAIN -> DONE on the edge where level==0, or becomes 0 via the pop in that cycle.
- DONE: terminal until reset; test_has_ended=1; FIFO empty; test_ending ignored thereafter.
- Read/write pointers wrap modulo DEPTH; full/empty from level, not pointer compare.
- out_data undefined-but-stable when out_valid==0 (bench must not check).

## Timing
- Reset values: out_valid 0, fifo_level 0, overflow_cnt 0, test_has_ended 0, out_data 0, state RUN, pointers 0.
- reset_n assertion mid-operation: immediate flush, all of the above restored asynchronously; no partial words survive.
- Write latency: push accepted at edge N into empty FIFO -> out_valid=1 and out_data valid after edge N.
- Pop at edge N -> next word presented after edge N (FWFT, no bubble).
- test_ending sampled at edge N with FIFO empty -> DRAIN after N, DONE and test_has_ended=1 after N+1.
- All outputs registered or decoded from registers only; no combinational path from out_ready to out_valid.

## Configuration
- CORE8_OCI_TRACE_TS_EN defined: free-running TS_W-bit counter (reset 0, wraps) captured into out_data MSBs at the accepting edge; W = TS_W+CNT_W+DCT_W.
- Not defined: no counter, W = CNT_W+DCT_W; TS_W unused.

## Test plan
- Reset, push {count=3, buffer=30'h0ABCDEF} -> out_valid=1 next cycle, out_data={4'h3,30'h0ABCDEF}, fifo_level=1.
- DEPTH=16, out_ready=0, 20 pushes with count=1 -> fifo_level=16, overflow_cnt=4; then drain -> 16 words in push order.
- Full FIFO, push and pop same cycle -> fifo_level stays 16, new word delivered last, overflow_cnt unchanged.
- Push with dct_count=0 for 5 cycles -> fifo_level 0, overflow_cnt 0.
- 3 words queued, test_ending=1 while pushes continue, out_ready=1 -> exactly 3 (+1 same-edge) words out, test_has_ended=1 the edge level hits 0, stays 1.
- With CORE8_OCI_TRACE_TS_EN, pushes at cycles 5 and 9 after reset -> timestamps differ by 4; assert reset_n mid-drain -> all outputs to reset values immediately.
